// File: rtl/input_cond_pkg.sv
// Shared defaults and sizing helper for the pad input conditioner.
// Imported by the per-bit cell and by the top level.
package input_cond_pkg;

    localparam int   DEF_WIDTH       = 8;
    localparam int   DEF_SYNC_STAGES = 2;
    localparam int   DEF_FILTER_LEN  = 4;
    localparam logic DEF_RESET_VALUE = 1'b0;

    // Bits needed to hold 0..filter_len; never narrower than one bit.
    function automatic int cnt_width(input int filter_len);
        int w;
        w = 0;
        while ((1 << w) < (filter_len + 1)) begin
            w = w + 1;
        end
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/input_cond_bit.sv
// One conditioned input: synchronizer chain, stability filter and
// registered rise/fall pulses that coincide with the level change.
module input_cond_bit
    import input_cond_pkg::*;
#(
    parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int   FILTER_LEN  = DEF_FILTER_LEN,
    parameter logic RESET_VALUE = DEF_RESET_VALUE
) (
    input  logic clock,
    input  logic reset,
    input  logic pad_in,
    output logic sync_out,
    output logic level_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int              CW       = cnt_width(FILTER_LEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(FILTER_LEN - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_sync_out;

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pad_in};
        end
    end

    // The counter only advances while the synchronized input disagrees with
    // the filtered level; any return to agreement restarts the run.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_level <= RESET_VALUE;
            r_cnt   <= '0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (w_sync_out == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= w_sync_out;
                r_cnt   <= '0;
                r_rise  <= w_sync_out;
                r_fall  <= ~w_sync_out;
            end else begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    assign sync_out   = w_sync_out;
    assign level_out  = r_level;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;

endmodule

// File: rtl/input_conditioner.sv
// Pad-side conditioning for WIDTH independent asynchronous inputs: raw
// buffered copy plus synchronized, glitch-filtered level and edge pulses.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int   WIDTH       = DEF_WIDTH,
    parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int   FILTER_LEN  = DEF_FILTER_LEN,
    parameter logic RESET_VALUE = DEF_RESET_VALUE
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] pad_in,
    output logic [WIDTH-1:0] raw_out,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);

    // Buffer equivalent: deliberately untouched by reset.
    assign raw_out = pad_in;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        input_cond_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_LEN  (FILTER_LEN),
            .RESET_VALUE (RESET_VALUE)
        ) u_bit (
            .clock      (clock),
            .reset      (reset),
            .pad_in     (pad_in[g]),
            .sync_out   (sync_out[g]),
            .level_out  (level_out[g]),
            .rise_pulse (rise_pulse[g]),
            .fall_pulse (fall_pulse[g])
        );
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: a default build and a SYNC_STAGES=3 /
// FILTER_LEN=1 build share one stimulus and a windowed reference model.
module tb_input_conditioner;

    localparam int W    = 8;
    localparam int MAXN = 2048;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] pad_in;

    logic [W-1:0] raw_a, sync_a, level_a, rise_a, fall_a;
    logic [W-1:0] raw_b, sync_b, level_b, rise_b, fall_b;

    always #5 clock = ~clock;

    input_conditioner #(
        .WIDTH(W), .SYNC_STAGES(2), .FILTER_LEN(4), .RESET_VALUE(1'b0)
    ) dut_a (
        .clock(clock), .reset(reset), .pad_in(pad_in),
        .raw_out(raw_a), .sync_out(sync_a), .level_out(level_a),
        .rise_pulse(rise_a), .fall_pulse(fall_a)
    );

    input_conditioner #(
        .WIDTH(W), .SYNC_STAGES(3), .FILTER_LEN(1), .RESET_VALUE(1'b0)
    ) dut_b (
        .clock(clock), .reset(reset), .pad_in(pad_in),
        .raw_out(raw_b), .sync_out(sync_b), .level_out(level_b),
        .rise_pulse(rise_b), .fall_pulse(fall_b)
    );

    // Per-edge history of what was sampled, and the model's level after each edge.
    logic [W-1:0] h_pad [MAXN];
    bit           h_rst [MAXN];
    logic [W-1:0] lvl_a [MAXN];
    logic [W-1:0] lvl_b [MAXN];
    int           n = -1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s edge=%0d got=%h expected=%h", tag, n, got, exp);
        end
    endtask

    // Synchronizer output after edge e: the pad value sampled SS-1 edges
    // earlier, or the reset value if a reset edge lies in that span.
    function automatic logic [W-1:0] model_sync(input int e, input int ss);
        int lo;
        lo = e - ss + 1;
        if (lo < 0) return '0;
        for (int m = lo; m <= e; m++) begin
            if (h_rst[m]) return '0;
        end
        return h_pad[lo];
    endfunction

    // A bit flips at edge e when the synchronized value disagreed with the
    // level for the whole preceding window of f edges with no reset inside.
    function automatic logic [W-1:0] model_level(input int e, input int ss, input int f,
                                                 input logic [W-1:0] prev);
        logic [W-1:0] nxt;
        logic [W-1:0] s;
        bit           held;
        nxt = prev;
        if (h_rst[e]) return '0;
        if (e - f < 0) return prev;
        for (int m = e - f; m <= e; m++) begin
            if (h_rst[m]) return prev;
        end
        for (int b = 0; b < W; b++) begin
            held = 1'b1;
            for (int m = e - f; m < e; m++) begin
                s = model_sync(m, ss);
                if (s[b] == prev[b]) held = 1'b0;
            end
            if (held) nxt[b] = ~prev[b];
        end
        return nxt;
    endfunction

    task automatic step(input logic [W-1:0] p, input logic r);
        logic [W-1:0] pa, pb;
        pad_in = p;
        reset  = r;
        #1;
        check_eq("raw_a", raw_a, p);
        check_eq("raw_b", raw_b, p);
        @(posedge clock);
        n++;
        if (n >= MAXN) begin
            $display("FAIL history_overflow edge=%0d got=%0d expected<%0d", n, n, MAXN);
            $fatal(1, "history overflow");
        end
        h_pad[n] = p;
        h_rst[n] = r;
        pa = (n == 0) ? '0 : lvl_a[n-1];
        pb = (n == 0) ? '0 : lvl_b[n-1];
        lvl_a[n] = model_level(n, 2, 4, pa);
        lvl_b[n] = model_level(n, 3, 1, pb);
        #1;
        check_eq("sync_a",  sync_a,  model_sync(n, 2));
        check_eq("level_a", level_a, lvl_a[n]);
        check_eq("rise_a",  rise_a,  r ? '0 : (lvl_a[n] & ~pa));
        check_eq("fall_a",  fall_a,  r ? '0 : (~lvl_a[n] & pa));
        check_eq("both_a",  rise_a & fall_a, '0);
        check_eq("sync_b",  sync_b,  model_sync(n, 3));
        check_eq("level_b", level_b, lvl_b[n]);
        check_eq("rise_b",  rise_b,  r ? '0 : (lvl_b[n] & ~pb));
        check_eq("fall_b",  fall_b,  r ? '0 : (~lvl_b[n] & pb));
    endtask

    task automatic hold(input logic [W-1:0] p, input int cycles);
        for (int i = 0; i < cycles; i++) step(p, 1'b0);
    endtask

    initial begin
        logic [W-1:0] acc_r, acc_f, cur;
        int           cnt, rise_at, hold_left;

        pad_in = '0;
        reset  = 1'b1;

        // Reset held with a non-zero pad pattern.
        for (int i = 0; i < 3; i++) step(8'hA5, 1'b1);
        check_eq("reset_level", level_a, 8'h00);
        check_eq("reset_sync",  sync_a,  8'h00);
        hold(8'h00, 10);

        // Clean rise then fall on bit 0; pulse 5 edges after the sampling edge.
        rise_at = -1;
        for (int i = 0; i < 10; i++) begin
            step(8'h01, 1'b0);
            if (rise_a[0] && rise_at < 0) rise_at = i;
        end
        check_eq("clean_rise_lat", 8'(rise_at), 8'd5);
        rise_at = -1;
        for (int i = 0; i < 10; i++) begin
            step(8'h00, 1'b0);
            if (fall_a[0] && rise_at < 0) rise_at = i;
        end
        check_eq("clean_fall_lat", 8'(rise_at), 8'd5);

        // Three-cycle glitch on bit 3 is rejected; four cycles gets through.
        acc_r = '0; acc_f = '0;
        for (int i = 0; i < 3; i++) begin step(8'h08, 1'b0); acc_r |= rise_a; acc_f |= fall_a; end
        for (int i = 0; i < 10; i++) begin step(8'h00, 1'b0); acc_r |= rise_a; acc_f |= fall_a; end
        check_eq("glitch3_rise", acc_r, 8'h00);
        check_eq("glitch3_fall", acc_f, 8'h00);
        acc_r = '0; acc_f = '0;
        for (int i = 0; i < 4; i++) begin step(8'h08, 1'b0); acc_r |= rise_a; acc_f |= fall_a; end
        for (int i = 0; i < 10; i++) begin step(8'h00, 1'b0); acc_r |= rise_a; acc_f |= fall_a; end
        check_eq("glitch4_rise", acc_r, 8'h08);
        check_eq("glitch4_fall", acc_f, 8'h08);

        // All bits together: one cycle of rise_pulse = FF.
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(8'hFF, 1'b0);
            if (rise_a == 8'hFF) cnt++;
        end
        check_eq("parallel_count", 8'(cnt), 8'd1);
        check_eq("parallel_level", level_a, 8'hFF);
        hold(8'h00, 10);

        // Reset mid-filter on bit 2: no pulse at +5, pulse 5 edges after release.
        rise_at = -1;
        for (int i = 0; i < 14; i++) begin
            step(8'h04, (i == 3) ? 1'b1 : 1'b0);
            if (rise_a[2] && rise_at < 0) rise_at = i;
        end
        check_eq("rst_mid_lat", 8'(rise_at), 8'd9);
        hold(8'h00, 10);

        // Single-cycle pad pulse on bit 4 passes the FILTER_LEN=1 build.
        acc_r = '0; acc_f = '0;
        step(8'h10, 1'b0);
        for (int i = 0; i < 8; i++) begin step(8'h00, 1'b0); acc_r |= rise_b; acc_f |= fall_b; end
        check_eq("f1_pulse_rise", acc_r, 8'h10);
        check_eq("f1_pulse_fall", acc_f, 8'h10);

        // Random pad activity with mixed hold lengths and occasional reset.
        cur = '0;
        hold_left = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                step(cur, 1'b1);
            end else begin
                if (hold_left == 0) begin
                    cur = cur ^ W'($urandom);
                    hold_left = $urandom_range(1, 6);
                end
                hold_left--;
                step(cur, 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
